gray_seq_ctrl: RTL and testbench

Sequencer for a W-bit Gray-code counter.
- Accepts a start command with a step count and a direction.
- Steps the Gray output once per enabled clock until the count is exhausted, then reports completion.
- Used by higher-level test/stimulus logic that needs a bounded, glitch-free Gray sweep instead of a free-running counter.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_step_core.sv | 40 ++++
 rtl/gray_seq_ctrl.sv | 107 ++++++++++
 tb/tb_gray_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
// State encoding plus binary/Gray conversion functions.
package gray_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_core.sv
// Binary position register with a registered Gray image.
// q is loaded from the next binary value, so it never glitches.
module gray_step_core
    import gray_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         ck,
    input  logic         res,
    input  logic         en,
    input  logic         dir,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] b;
    logic [W-1:0] b_n;

    // Next binary position: clear, step up/down modulo 2^W, or hold
    always_comb begin
        b_n = b;
        if (clr) begin
            b_n = '0;
        end else if (en) begin
            b_n = dir ? (b - W'(1)) : (b + W'(1));
        end
    end

    // Binary and Gray registers update together on the same edge
    always_ff @(posedge ck) begin
        if (res) begin
            b <= '0;
            q <= '0;
        end else begin
            b <= b_n;
            q <= W'(bin2gray(32'(b_n)));
        end
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Bounded Gray-code sweep sequencer.
// Runs a counted number of steps in one direction, then pulses done.
module gray_seq_ctrl
    import gray_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         ck,
    input  logic         res,
    input  logic         start,
    input  logic [W-1:0] len,
    input  logic         dir,
    input  logic         pause,
    input  logic         zero,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

    state_t     state;
    state_t     nxt;
    logic [W:0] rem;
    logic [W:0] rem_n;
    logic       dir_r;
    logic       dir_n;
    logic       err_q;
    logic       en;
    logic       clr;
    logic [W:0] load;

    assign load = (len == '0) ? FULL : {1'b0, len};

    // Next-state, step count and core controls
    always_comb begin
        nxt   = state;
        rem_n = rem;
        dir_n = dir_r;
        en    = 1'b0;
        clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    rem_n = load;
                    dir_n = dir;
                    nxt   = S_RUN;
                end else if (zero) begin
                    clr = 1'b1;
                end
            end
            S_RUN: begin
                if (!pause) begin
                    en    = 1'b1;
                    rem_n = rem - (W+1)'(1);
                    if (rem == (W+1)'(1)) begin
                        nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    rem_n = load;
                    dir_n = dir;
                    nxt   = S_RUN;
                end else begin
                    nxt = S_IDLE;
                end
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // Control state, remaining count, latched direction and err pulse
    always_ff @(posedge ck) begin
        if (res) begin
            state <= S_IDLE;
            rem   <= '0;
            dir_r <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= nxt;
            rem   <= rem_n;
            dir_r <= dir_n;
            err_q <= (state == S_RUN) && start;
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign err  = err_q;

    gray_step_core #(
        .W(W)
    ) u_core (
        .ck (ck),
        .res(res),
        .en (en),
        .dir(dir_r),
        .clr(clr),
        .q  (q)
    );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl.
// Expected outputs are queued as stimulus is applied and popped per cycle.
module tb_gray_seq_ctrl;
    import gray_pkg::*;

    localparam int W = 3;

    logic         ck = 1'b0;
    logic         res = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] len = '0;
    logic         dir = 1'b0;
    logic         pause = 1'b0;
    logic         zero = 1'b0;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         err;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         err;
    } obs_t;

    obs_t sb[$];
    obs_t got[$];
    int   vecs = 0;
    int   miss = 0;

    gray_seq_ctrl #(
        .W(W)
    ) dut (
        .ck   (ck),
        .res  (res),
        .start(start),
        .len  (len),
        .dir  (dir),
        .pause(pause),
        .zero (zero),
        .q    (q),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 ck = ~ck;

    function automatic obs_t x(input logic [W-1:0] qq, input logic b,
                               input logic d, input logic e);
        return {qq, b, d, e};
    endfunction

    // Apply one cycle of inputs, queue the expected post-edge outputs
    task automatic step(input logic s, input logic [W-1:0] l,
                        input logic d, input logic p, input logic z,
                        input logic r, input obs_t e);
        start = s; len = l; dir = d;
        pause = p; zero = z; res = r;
        sb.push_back(e);
        @(posedge ck);
        #1;
        got.push_back({q, busy, done, err});
        start = 1'b0; pause = 1'b0;
        zero = 1'b0; res = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        step(0, 0, 0, 0, 0, 1, x(3'b000, 0, 0, 0));
        step(1, 3, 0, 0, 1, 1, x(3'b000, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b000, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = got.pop_front(); vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL reset[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_up3();
        obs_t e, o;
        step(1, 3, 0, 0, 0, 0, x(3'b000, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b001, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b011, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b010, 0, 1, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b010, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = got.pop_front(); vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL up3[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t e, o;
        logic [W-1:0] seq [8] = '{3'b110, 3'b111, 3'b101, 3'b100,
                                  3'b000, 3'b001, 3'b011, 3'b010};
        logic [W-1:0] prev;
        logic [W-1:0] bin;
        step(1, 0, 0, 0, 0, 0, x(3'b010, 1, 0, 0));
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 0, x(seq[i], i < 7, i == 7, 0));
        end
        step(0, 0, 0, 0, 0, 0, x(3'b010, 0, 0, 0));
        prev = 3'd3;
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = got.pop_front(); vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL wrap[%0d]: got %b want %b", i, o, e);
            end
            if (i >= 1 && i <= 8) begin
                bin = W'(gray2bin(32'(o.q)));
                vecs++;
                if (bin !== prev + W'(1)) begin
                    miss++;
                    $display("FAIL wrap_bin[%0d]: got %0d want %0d",
                             i, bin, prev + W'(1));
                end
                prev = prev + W'(1);
            end
        end
    endtask

    task automatic test_down2();
        obs_t e, o;
        step(0, 0, 0, 0, 1, 0, x(3'b000, 0, 0, 0));
        step(1, 2, 1, 0, 0, 0, x(3'b000, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b100, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b101, 0, 1, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b101, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = got.pop_front(); vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL down2[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_pause();
        obs_t e, o;
        step(1, 4, 0, 0, 0, 0, x(3'b101, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b100, 1, 0, 0));
        step(0, 0, 0, 1, 0, 0, x(3'b100, 1, 0, 0));
        step(1, 1, 1, 1, 0, 0, x(3'b100, 1, 0, 1));
        step(0, 0, 0, 1, 0, 0, x(3'b100, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b000, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b001, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b011, 0, 1, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b011, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = got.pop_front(); vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL pause[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_zero_abort();
        obs_t e, o;
        step(0, 0, 0, 0, 1, 0, x(3'b000, 0, 0, 0));
        step(1, 3, 0, 0, 0, 0, x(3'b000, 1, 0, 0));
        step(0, 0, 0, 0, 1, 0, x(3'b001, 1, 0, 0));
        step(0, 0, 0, 0, 0, 1, x(3'b000, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b000, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b000, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = got.pop_front(); vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL zero_abort[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        step(1, 2, 0, 0, 0, 0, x(3'b000, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b001, 1, 0, 0));
        step(1, 5, 1, 0, 0, 0, x(3'b011, 0, 1, 1));
        step(1, 1, 1, 0, 0, 0, x(3'b011, 1, 0, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b001, 0, 1, 0));
        step(0, 0, 0, 0, 0, 0, x(3'b001, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = got.pop_front(); vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL b2b[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up3();
        test_wrap();
        test_down2();
        test_pause();
        test_zero_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
